afu_ctrl_regs: RTL and testbench

- AXI4-Lite slave control block for the Vortex accelerator wrapper.
- Exposes Vitis-style ap_ctrl handshake registers, interrupt enable/status registers, read-only capability registers and a device-config-register (DCR) write port.
- Sits between the host control bus and the AFU state machine and the GPU DCR input.

---
 rtl/afu_ctrl_regs_pkg.sv | 35 +++
 rtl/afu_ctrl_regs.sv | 192 +++++++++++++++++++
 tb/tb_afu_ctrl_regs.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_ctrl_regs_pkg.sv
// Shared definitions for the AFU AXI4-Lite control register block:
// register map, AP_CTRL bit positions and channel FSM states.
package afu_ctrl_regs_pkg;

  localparam int unsigned REG_ADDR_W = 8;

  localparam logic [REG_ADDR_W-1:0] ADDR_AP_CTRL    = 8'h00;
  localparam logic [REG_ADDR_W-1:0] ADDR_GIE        = 8'h04;
  localparam logic [REG_ADDR_W-1:0] ADDR_IER        = 8'h08;
  localparam logic [REG_ADDR_W-1:0] ADDR_ISR        = 8'h0C;
  localparam logic [REG_ADDR_W-1:0] ADDR_DEV_CAPS_0 = 8'h10;
  localparam logic [REG_ADDR_W-1:0] ADDR_DEV_CAPS_1 = 8'h14;
  localparam logic [REG_ADDR_W-1:0] ADDR_ISA_CAPS_0 = 8'h18;
  localparam logic [REG_ADDR_W-1:0] ADDR_ISA_CAPS_1 = 8'h1C;
  localparam logic [REG_ADDR_W-1:0] ADDR_DCR_0      = 8'h20;
  localparam logic [REG_ADDR_W-1:0] ADDR_DCR_1      = 8'h24;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;
  localparam int unsigned AP_READY_BIT = 3;
  localparam int unsigned AP_RESET_BIT = 4;

  typedef enum logic [1:0] {
    WRIDLE = 2'd0,
    WRDATA = 2'd1,
    WRRESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RDIDLE = 1'b0,
    RDDATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/afu_ctrl_regs.sv
// AXI4-Lite control slave for the accelerator wrapper: ap_ctrl handshake,
// interrupt registers, capability constants and a DCR write port.
module afu_ctrl_regs #(
  parameter int unsigned  S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned  S_AXI_DATA_WIDTH = 32,
  parameter int unsigned  DCR_ADDR_WIDTH   = 12,
  parameter int unsigned  DCR_DATA_WIDTH   = 32,
  parameter logic [63:0]  DEV_CAPS         = 64'h0,
  parameter logic [63:0]  ISA_CAPS         = 64'h0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          ap_start,
  output logic                          ap_reset,
  input  logic                          ap_done,
  input  logic                          ap_ready,
  input  logic                          ap_idle,
  output logic                          ap_ctrl_read,
  output logic                          interrupt,
  output logic                          dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0]     dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0]     dcr_wr_data
);
  import afu_ctrl_regs_pkg::*;

  localparam int unsigned DATA_W = S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = S_AXI_DATA_WIDTH / 8;

  wr_state_e             wr_state, wr_state_next;
  rd_state_e             rd_state, rd_state_next;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_ctrl, wr_ap_ctrl, wr_gie, wr_ier, wr_isr, wr_dcr_addr, wr_dcr_data;
  logic                  done_flag, done_q, ready_q, gie;
  logic [1:0]            ier, isr, isr_next;
  logic [DATA_W-1:0]     dcr_addr;
  logic [DATA_W-1:0]     rdata_next;

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  assign aw_hs = s_axi_awready && s_axi_awvalid;
  assign w_hs  = s_axi_wready && s_axi_wvalid;
  assign ar_hs = s_axi_arready && s_axi_arvalid;

  // Control registers only take byte 0; DCR registers decode independently of it.
  assign wr_ctrl     = w_hs && s_axi_wstrb[0];
  assign wr_ap_ctrl  = wr_ctrl && (wr_addr == ADDR_AP_CTRL);
  assign wr_gie      = wr_ctrl && (wr_addr == ADDR_GIE);
  assign wr_ier      = wr_ctrl && (wr_addr == ADDR_IER);
  assign wr_isr      = wr_ctrl && (wr_addr == ADDR_ISR);
  assign wr_dcr_addr = w_hs && (wr_addr == ADDR_DCR_0);
  assign wr_dcr_data = w_hs && (wr_addr == ADDR_DCR_1);

  assign ap_ctrl_read = ar_hs && (s_axi_araddr[REG_ADDR_W-1:0] == ADDR_AP_CTRL);

  // Channel state registers plus registered ready/valid decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state      <= WRIDLE;
      rd_state      <= RDIDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
    end else begin
      wr_state      <= wr_state_next;
      rd_state      <= rd_state_next;
      s_axi_awready <= (wr_state_next == WRIDLE);
      s_axi_wready  <= (wr_state_next == WRDATA);
      s_axi_bvalid  <= (wr_state_next == WRRESP);
      s_axi_arready <= (rd_state_next == RDIDLE);
      s_axi_rvalid  <= (rd_state_next == RDDATA);
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WRIDLE:  if (s_axi_awvalid) wr_state_next = WRDATA;
      WRDATA:  if (s_axi_wvalid)  wr_state_next = WRRESP;
      WRRESP:  if (s_axi_bready)  wr_state_next = WRIDLE;
      default: wr_state_next = WRIDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RDIDLE:  if (s_axi_arvalid) rd_state_next = RDDATA;
      RDDATA:  if (s_axi_rready)  rd_state_next = RDIDLE;
      default: rd_state_next = RDIDLE;
    endcase
  end

  // Read mux; done is reported as held before this read's clear takes effect.
  always_comb begin
    rdata_next = '0;
    case (s_axi_araddr[REG_ADDR_W-1:0])
      ADDR_AP_CTRL: begin
        rdata_next[AP_START_BIT] = ap_start;
        rdata_next[AP_DONE_BIT]  = done_flag;
        rdata_next[AP_IDLE_BIT]  = ap_idle;
        rdata_next[AP_READY_BIT] = ap_ready;
      end
      ADDR_GIE:        rdata_next[0]   = gie;
      ADDR_IER:        rdata_next[1:0] = ier;
      ADDR_ISR:        rdata_next[1:0] = isr;
      ADDR_DEV_CAPS_0: rdata_next = DATA_W'(DEV_CAPS[31:0]);
      ADDR_DEV_CAPS_1: rdata_next = DATA_W'(DEV_CAPS[63:32]);
      ADDR_ISA_CAPS_0: rdata_next = DATA_W'(ISA_CAPS[31:0]);
      ADDR_ISA_CAPS_1: rdata_next = DATA_W'(ISA_CAPS[63:32]);
      ADDR_DCR_0:      rdata_next = dcr_addr;
      default:         rdata_next = '0;
    endcase
  end

  // Hardware edge events override a host toggle landing in the same cycle.
  always_comb begin
    isr_next = isr;
    if (wr_isr) isr_next = isr ^ s_axi_wdata[1:0];
    if (ier[0] && ap_done && !done_q)   isr_next[0] = 1'b1;
    if (ier[1] && ap_ready && !ready_q) isr_next[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr      <= '0;
      s_axi_rdata  <= '0;
      ap_start     <= 1'b0;
      ap_reset     <= 1'b0;
      done_flag    <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      gie          <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
      interrupt    <= 1'b0;
      dcr_addr     <= '0;
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
    end else begin
      if (aw_hs) wr_addr <= s_axi_awaddr[REG_ADDR_W-1:0];
      if (ar_hs) s_axi_rdata <= rdata_next;

      if (ap_ready)                                  ap_start <= 1'b0;
      else if (wr_ap_ctrl && s_axi_wdata[AP_START_BIT]) ap_start <= 1'b1;
      ap_reset <= wr_ap_ctrl && s_axi_wdata[AP_RESET_BIT];

      if (ap_done)           done_flag <= 1'b1;
      else if (ap_ctrl_read) done_flag <= 1'b0;
      done_q  <= ap_done;
      ready_q <= ap_ready;

      if (wr_gie) gie <= s_axi_wdata[0];
      if (wr_ier) ier <= s_axi_wdata[1:0];
      isr       <= isr_next;
      interrupt <= gie && (|isr);

      if (wr_dcr_addr) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (s_axi_wstrb[i]) dcr_addr[8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
      dcr_wr_valid <= wr_dcr_data;
      if (wr_dcr_data) begin
        dcr_wr_addr <= DCR_ADDR_WIDTH'(dcr_addr);
        dcr_wr_data <= DCR_DATA_WIDTH'(s_axi_wdata);
      end
    end
  end

endmodule

// File: tb/tb_afu_ctrl_regs.sv
// Directed bench for afu_ctrl_regs: register map, ap_ctrl handshake,
// interrupts, DCR write port and asynchronous reset.
module tb_afu_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_axi_awvalid, s_axi_awready;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        ap_start, ap_reset, ap_done, ap_ready, ap_idle, ap_ctrl_read;
  logic        interrupt, dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;

  int n_cmp = 0;
  int n_fail = 0;
  int tmo = 0;
  int dcr_cnt = 0;
  int rst_cnt = 0;
  int crd_cnt = 0;
  logic [11:0] dcr_seen_addr = '0;
  logic [31:0] dcr_seen_data = '0;
  logic [31:0] rd;
  logic [1:0]  rr;
  int          base;

  always #5 clk = ~clk;

  afu_ctrl_regs #(
    .S_AXI_ADDR_WIDTH(8), .S_AXI_DATA_WIDTH(32), .DCR_ADDR_WIDTH(12), .DCR_DATA_WIDTH(32),
    .DEV_CAPS(64'h1234_5678_9ABC_DEF0), .ISA_CAPS(64'hCAFE_F00D_0BAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .ap_start(ap_start), .ap_reset(ap_reset), .ap_done(ap_done), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_ctrl_read(ap_ctrl_read), .interrupt(interrupt),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data)
  );

  // Pulse monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (dcr_wr_valid) begin
      dcr_cnt++;
      dcr_seen_addr = dcr_wr_addr;
      dcr_seen_data = dcr_wr_data;
    end
    if (ap_reset) rst_cnt++;
    if (ap_ctrl_read) crd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = a;
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(); n++; end
    if (n >= 20) tmo++;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    n = 0;
    while (!s_axi_wready && n < 20) begin tick(); n++; end
    if (n >= 20) tmo++;
    tick();
    s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) tmo++;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = a;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    if (n >= 20) tmo++;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    if (n >= 20) tmo++;
    d = s_axi_rdata;
    r = s_axi_rresp;
    tick();
    s_axi_rready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_wvalid = 1'b0; s_axi_wdata = '0;
    s_axi_wstrb = '0; s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = '0;
    s_axi_rready = 1'b0; ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b0;

    // Reset values
    #12;
    check("rst_awready", 32'(s_axi_awready), 32'd1);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_ap_start", 32'(ap_start), 32'd0);
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_dcr_valid", 32'(dcr_wr_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Capability constants and unmapped read
    axi_read(8'h10, rd, rr);
    check("dev_caps_lo", rd, 32'h9ABC_DEF0);
    check("dev_caps_lo_rresp", 32'(rr), 32'd0);
    axi_read(8'h14, rd, rr);
    check("dev_caps_hi", rd, 32'h1234_5678);
    axi_read(8'h18, rd, rr);
    check("isa_caps_lo", rd, 32'h0BAD_BEEF);
    axi_read(8'h1C, rd, rr);
    check("isa_caps_hi", rd, 32'hCAFE_F00D);
    axi_read(8'h30, rd, rr);
    check("unmapped_read", rd, 32'h0);

    // DCR write port
    axi_write(8'h20, 32'h0000_0001, 4'hF);
    axi_read(8'h20, rd, rr);
    check("dcr_addr_rd", rd, 32'h0000_0001);
    axi_write(8'h24, 32'hDEAD_BEEF, 4'hF);
    check("dcr_pulse_cnt", 32'(dcr_cnt), 32'd1);
    check("dcr_pulse_addr", 32'(dcr_seen_addr), 32'h001);
    check("dcr_pulse_data", dcr_seen_data, 32'hDEAD_BEEF);
    check("dcr_hold_addr", 32'(dcr_wr_addr), 32'h001);
    check("dcr_hold_data", dcr_wr_data, 32'hDEAD_BEEF);
    axi_read(8'h24, rd, rr);
    check("dcr_data_wo", rd, 32'h0);
    axi_write(8'h20, 32'hAABB_CCDD, 4'b0010);
    axi_read(8'h20, rd, rr);
    check("dcr_addr_merge", rd, 32'h0000_CC01);
    axi_write(8'h24, 32'h1234_5678, 4'b0001);
    check("dcr_pulse_cnt2", 32'(dcr_cnt), 32'd2);
    check("dcr_pulse_addr2", 32'(dcr_seen_addr), 32'hC01);
    check("dcr_pulse_data2", dcr_seen_data, 32'h1234_5678);

    // ap_start set, readback, clear by ap_ready
    axi_write(8'h00, 32'h1, 4'h0);
    check("start_strb0_ignored", 32'(ap_start), 32'd0);
    axi_write(8'h00, 32'h1, 4'hF);
    check("start_set", 32'(ap_start), 32'd1);
    axi_read(8'h00, rd, rr);
    check("ap_ctrl_start_rd", rd, 32'h1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    check("start_cleared", 32'(ap_start), 32'd0);
    ap_ready = 1'b1;
    axi_write(8'h00, 32'h1, 4'hF);
    ap_ready = 1'b0;
    tick();
    check("start_clear_wins", 32'(ap_start), 32'd0);

    // Sticky done, clear-on-read, ap_ctrl_read pulse
    ap_idle = 1'b1;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    base = crd_cnt;
    axi_read(8'h00, rd, rr);
    check("done_sticky_rd", rd, 32'h6);
    check("ctrl_read_pulse", 32'(crd_cnt - base), 32'd1);
    axi_read(8'h00, rd, rr);
    check("done_cleared_rd", rd, 32'h4);
    check("ctrl_read_pulse2", 32'(crd_cnt - base), 32'd2);
    ap_idle = 1'b0;

    // Interrupt path
    axi_write(8'h04, 32'h1, 4'hF);
    axi_write(8'h08, 32'h1, 4'hF);
    check("irq_idle", 32'(interrupt), 32'd0);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    tick();
    tick();
    check("irq_asserted", 32'(interrupt), 32'd1);
    axi_read(8'h0C, rd, rr);
    check("isr_set", rd, 32'h1);
    axi_write(8'h0C, 32'h1, 4'hF);
    check("irq_cleared", 32'(interrupt), 32'd0);
    axi_read(8'h0C, rd, rr);
    check("isr_toggled", rd, 32'h0);

    // Soft reset pulse
    axi_write(8'h00, 32'h10, 4'hF);
    tick();
    check("ap_reset_one_cycle", 32'(rst_cnt), 32'd1);
    check("ap_reset_no_start", 32'(ap_start), 32'd0);

    // Asynchronous reset during a write response
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = 8'h04;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = 32'h1;
    s_axi_wstrb   = 4'hF;
    tick();
    s_axi_wvalid = 1'b0;
    check("midwrite_bvalid", 32'(s_axi_bvalid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("async_rst_awready", 32'(s_axi_awready), 32'd1);
    check("async_rst_dcr_addr", 32'(dcr_wr_addr), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    axi_read(8'h04, rd, rr);
    check("gie_after_reset", rd, 32'h0);
    axi_read(8'h20, rd, rr);
    check("dcr_addr_after_reset", rd, 32'h0);

    check("handshake_timeouts", 32'(tmo), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
